// File: rtl/mod_exp_unit.sv
// Multi-cycle modular exponentiation / modulo engine (right-to-left square-and-multiply).
// Optional build macro MODEXP_EARLY_EXIT_EN: stop iterating once the exponent is exhausted.

package alu_defs;
  localparam logic [2:0] ARITH_MOD = 3'b101;
  localparam logic [2:0] ARITH_EXP = 3'b110;
endpackage

module mod_exp_unit
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_LOOP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_base;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic [WIDTH-1:0] w_n_safe;
  logic [PW-1:0]    w_prod_rb;
  logic [PW-1:0]    w_prod_bb;
  logic [WIDTH-1:0] w_r_mul;
  logic [WIDTH-1:0] w_base_sq;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_a_mod;
  logic             w_op_ok;
  logic             w_n_zero;
  logic             w_n_one;
  logic             w_last;

  // Divisor forced nonzero so the reducers never see n == 0; that case is trapped in INIT.
  assign w_n_safe  = (r_n == '0) ? WIDTH'(1) : r_n;
  assign w_n_zero  = (r_n == '0);
  assign w_n_one   = (r_n == WIDTH'(1));
  assign w_op_ok   = (r_op == ARITH_EXP) || (r_op == ARITH_MOD);

  assign w_prod_rb = PW'(r_r) * PW'(r_base);
  assign w_prod_bb = PW'(r_base) * PW'(r_base);
  assign w_r_mul   = WIDTH'(w_prod_rb % PW'(w_n_safe));
  assign w_base_sq = WIDTH'(w_prod_bb % PW'(w_n_safe));
  assign w_r_next  = r_e[0] ? w_r_mul : r_r;
  assign w_a_mod   = r_a % w_n_safe;

`ifdef MODEXP_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_e >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_r      <= '0;
      r_base   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_e     <= b;
            r_n     <= n;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_INIT: begin
          if (w_n_zero || !w_op_ok) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_op == ARITH_MOD) begin
            r_result <= w_a_mod;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
`ifdef MODEXP_EARLY_EXIT_EN
          end else if (r_e == '0) begin
            r_result <= w_n_one ? '0 : WIDTH'(1);
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
`endif
          end else begin
            r_r     <= w_n_one ? '0 : WIDTH'(1);
            r_base  <= w_a_mod;
            r_cnt   <= '0;
            r_state <= S_LOOP;
          end
        end
        S_LOOP: begin
          r_r    <= w_r_next;
          r_base <= w_base_sq;
          r_e    <= r_e >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_r_next;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Directed-vector bench for mod_exp_unit; expected latencies follow MODEXP_EARLY_EXIT_EN.

module tb_mod_exp_unit;

  localparam int unsigned WIDTH  = 16;
  localparam int          BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  int vectors     = 0;
  int miscompares = 0;

  mod_exp_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from accepted start to done for an EXP with exponent e.
  function automatic int exp_lat(input logic [WIDTH-1:0] e);
`ifdef MODEXP_EARLY_EXIT_EN
    int len;
    len = 0;
    for (int i = 0; i < WIDTH; i++) if (e[i]) len = i + 1;
    return len + 2;
`else
    return WIDTH + 2;
`endif
  endfunction

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vn);
    op = o; a = va; b = vb; n = vn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vn,
                        input int exp_res, input int exp_err, input int lat_req);
    int lat;
    int busy_cnt;
    issue(o, va, vb, vn);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(lat_req));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(lat_req - 1));
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int lat;
    int second;
    int done_seen;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; n = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.err", 32'(err), 32'd0);
    tick();

    run_op("exp65", 3'b110, 16'd65, 16'd17, 16'd3233, 2790, 0, exp_lat(16'd17));
    run_op("exp4", 3'b110, 16'd4, 16'd13, 16'd497, 445, 0, exp_lat(16'd13));
    run_op("exp_b0", 3'b110, 16'd4, 16'd0, 16'd497, 1, 0, exp_lat(16'd0));
    run_op("exp_n1", 3'b110, 16'd5, 16'd3, 16'd1, 0, 0, exp_lat(16'd3));
    run_op("mod", 3'b101, 16'd1000, 16'd0, 16'd7, 6, 0, 2);
    run_op("bad_op", 3'b000, 16'd5, 16'd3, 16'd7, 0, 1, 2);
    run_op("mod_clr", 3'b101, 16'd50, 16'd0, 16'd9, 5, 0, 2);
    run_op("exp_n0", 3'b110, 16'd5, 16'd3, 16'd0, 0, 1, 2);

    // Starts during INIT/LOOP are ignored; start in the done cycle is accepted.
    second = (exp_lat(16'd17) > 10) ? 10 : 5;
    issue(3'b110, 16'd65, 16'd17, 16'd3233);
    lat = 1;
    while (!done && lat < BUDGET) begin
      if (lat == 3 || lat == second) begin
        start = 1'b1; op = 3'b110; a = 16'd4; b = 16'd13; n = 16'd497;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("ign.done", 32'(done), 32'd1);
    check("ign.lat", 32'(lat), 32'(exp_lat(16'd17)));
    check("ign.result", 32'(result), 32'd2790);
    check("ign.err", 32'(err), 32'd0);
    op = 3'b101; a = 16'd1000; b = 16'd0; n = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.done", 32'(done), 32'd0);
    check("b2b.result_held", 32'(result), 32'd2790);
    tick();
    check("b2b.done2", 32'(done), 32'd1);
    check("b2b.result", 32'(result), 32'd6);
    tick();

    // Reset in cycle C+8 of a long EXP aborts it.
    issue(3'b110, 16'd65, 16'hFFFF, 16'd3233);
    lat = 1;
    done_seen = 0;
    while (lat < 8) begin
      tick();
      lat++;
      if (done) done_seen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.early_done", 32'(done_seen), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("rst.quiet", 32'(done_seen), 32'd0);

    run_op("post_rst", 3'b110, 16'd4, 16'd13, 16'd497, 445, 0, exp_lat(16'd13));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
